// File: rtl/picorv_mem_pkg.sv
// Shared types and default constants for the PicoRV32 / host SRAM arbiter.
package picorv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_HOST = 2'd2
  } grant_e;

  localparam int unsigned DEFAULT_MEM_SIZE      = 4096;
  localparam logic [31:0] DEFAULT_OUT_BYTE_ADDR = 32'h1000_0000;

endpackage

// File: rtl/picorv_mem_arbiter_if.sv
// CPU, host and SRAM-side signals of the firmware SRAM arbiter.
interface picorv_mem_arbiter_if #(
  parameter int unsigned AW = 12
) ();

  logic          cpu_valid;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [3:0]    cpu_wstrb;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic          host_ack;
  logic [31:0]   host_rdata;

  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  logic [7:0]    out_byte;
  logic          out_byte_en;
  logic [31:0]   host_wait_cycles;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  host_req, host_we, host_addr, host_wdata,
    input  sram_rdata,
    output cpu_ready, cpu_rdata, host_ack, host_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    output out_byte, out_byte_en, host_wait_cycles
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output host_req, host_we, host_addr, host_wdata,
    output sram_rdata,
    input  cpu_ready, cpu_rdata, host_ack, host_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    input  out_byte, out_byte_en, host_wait_cycles
  );

endinterface

// File: rtl/picorv_mem_grant.sv
// CPU-priority arbitration with a saturating host starvation counter.
module picorv_mem_grant
  import picorv_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   cpu_pend,
  input  logic   host_pend,
  input  logic   arb_en,
  output grant_e gnt
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_q, starve_d;

  always_comb begin
    gnt = GNT_NONE;
    if (arb_en) begin
      if (cpu_pend && !(host_pend && starve_q == LIMIT)) begin
        gnt = GNT_CPU;
      end else if (host_pend) begin
        gnt = GNT_HOST;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!host_pend || gnt == GNT_HOST) begin
      starve_d = '0;
    end else if (gnt == GNT_CPU && starve_q != LIMIT) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/picorv_mem_arbiter.sv
// Shares the firmware SRAM between picorv32 and the host port; decodes out_byte MMIO.
// Optional host wait-cycle counter is built when ARB_PERF_CNT_EN is defined.
module picorv_mem_arbiter
  import picorv_mem_pkg::*;
#(
  parameter int unsigned MEM_SIZE      = DEFAULT_MEM_SIZE,
  parameter int unsigned AW            = 12,
  parameter int unsigned STARVE_LIMIT  = 8,
  parameter logic [31:0] OUT_BYTE_ADDR = DEFAULT_OUT_BYTE_ADDR
) (
  input logic                 clk,
  input logic                 resetn,
  picorv_mem_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  grant_e        owner_q;
  grant_e        gnt;
  logic          resp_rd_q;
  logic          resp_mmio_q;
  logic          sram_en_q;
  logic [3:0]    sram_we_q;
  logic [AW-1:0] sram_addr_q;
  logic [31:0]   sram_wdata_q;
  logic [7:0]    out_byte_q;
  logic [31:0]   cpu_rdata_q;
  logic [31:0]   host_rdata_q;
  logic [31:0]   resp_data;
  logic          cpu_mmio;
  logic          cpu_oor;
  logic          arb_en;

  assign cpu_mmio = (bus.cpu_addr == OUT_BYTE_ADDR) && (bus.cpu_wstrb != 4'h0);
  assign cpu_oor  = (bus.cpu_addr >> 2) >= 32'(MEM_SIZE);
  assign arb_en   = (state_q == IDLE);

  picorv_mem_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk      (clk),
    .resetn   (resetn),
    .cpu_pend (bus.cpu_valid),
    .host_pend(bus.host_req),
    .arb_en   (arb_en),
    .gnt      (gnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt == GNT_CPU) begin
          state_d = (cpu_mmio || cpu_oor) ? RESP : ACCESS;
        end else if (gnt == GNT_HOST) begin
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= GNT_NONE;
      resp_rd_q    <= 1'b0;
      resp_mmio_q  <= 1'b0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      out_byte_q   <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      sram_en_q <= 1'b0;
      sram_we_q <= '0;
      case (state_q)
        IDLE: begin
          case (gnt)
            GNT_CPU: begin
              owner_q     <= GNT_CPU;
              resp_mmio_q <= cpu_mmio;
              resp_rd_q   <= !cpu_mmio && !cpu_oor && (bus.cpu_wstrb == 4'h0);
              if (cpu_mmio) begin
                out_byte_q <= bus.cpu_wdata[7:0];
              end else if (!cpu_oor) begin
                sram_en_q    <= 1'b1;
                sram_we_q    <= bus.cpu_wstrb;
                sram_addr_q  <= bus.cpu_addr[AW+1:2];
                sram_wdata_q <= bus.cpu_wdata;
              end
            end
            GNT_HOST: begin
              owner_q      <= GNT_HOST;
              resp_mmio_q  <= 1'b0;
              resp_rd_q    <= !bus.host_we;
              sram_en_q    <= 1'b1;
              sram_we_q    <= {4{bus.host_we}};
              sram_addr_q  <= bus.host_addr;
              sram_wdata_q <= bus.host_wdata;
            end
            default: ;
          endcase
        end
        RESP: begin
          if (owner_q == GNT_CPU) begin
            cpu_rdata_q <= resp_data;
          end else if (owner_q == GNT_HOST) begin
            host_rdata_q <= resp_data;
          end
        end
        default: ;
      endcase
    end
  end

  // SRAM read data only arrives during RESP, so the pulse cycle bypasses the holding register.
  assign resp_data       = resp_rd_q ? bus.sram_rdata : '0;
  assign bus.cpu_ready   = (state_q == RESP) && (owner_q == GNT_CPU);
  assign bus.host_ack    = (state_q == RESP) && (owner_q == GNT_HOST);
  assign bus.cpu_rdata   = bus.cpu_ready ? resp_data : cpu_rdata_q;
  assign bus.host_rdata  = bus.host_ack ? resp_data : host_rdata_q;
  assign bus.out_byte_en = (state_q == RESP) && resp_mmio_q;
  assign bus.out_byte    = out_byte_q;
  assign bus.sram_en     = sram_en_q;
  assign bus.sram_we     = sram_we_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_wdata  = sram_wdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] wait_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_q <= '0;
    end else if (bus.host_req && gnt != GNT_HOST) begin
      wait_q <= wait_q + 32'd1;
    end
  end

  assign bus.host_wait_cycles = wait_q;
`else
  assign bus.host_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_picorv_mem_arbiter.sv
// Randomized self-checking bench for picorv_mem_arbiter with a transaction-level reference.
module tb_picorv_mem_arbiter;

  localparam int unsigned MEM_SIZE     = 4096;
  localparam int unsigned AW           = 12;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam logic [31:0] OB_ADDR      = 32'h1000_0000;
  localparam int unsigned NWORDS       = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  picorv_mem_arbiter_if #(.AW(AW)) bus ();

  picorv_mem_arbiter #(
    .MEM_SIZE     (MEM_SIZE),
    .AW           (AW),
    .STARVE_LIMIT (STARVE_LIMIT),
    .OUT_BYTE_ADDR(OB_ADDR)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Synchronous single-port SRAM: read data appears the cycle after sram_en.
  logic [31:0] sram_mem [MEM_SIZE];
  always @(posedge clk) begin
    if (bus.sram_en) begin
      sram_mem[bus.sram_addr] <= merge(sram_mem[bus.sram_addr], bus.sram_wdata, bus.sram_we);
      bus.sram_rdata <= sram_mem[bus.sram_addr];
    end
  end

  logic [31:0] gold [NWORDS];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called and returns at 1 time unit after a rising edge with the arbiter idle.
  task automatic cpu_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output int lat, output int en_cyc,
                        output logic obe, output logic [7:0] ob);
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_wstrb = s;
    lat = 0;
    en_cyc = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      en_cyc += int'(bus.sram_en);
    end while (!bus.cpu_ready && lat < 20);
    check("cpu_done", bus.cpu_ready, 1);
    rd  = bus.cpu_rdata;
    obe = bus.out_byte_en;
    ob  = bus.out_byte;
    bus.cpu_valid = 1'b0;
    @(posedge clk); #1;
    en_cyc += int'(bus.sram_en);
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.host_ack && lat < 20);
    check("host_done", bus.host_ack, 1);
    rd = bus.host_rdata;
    bus.host_req = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic [7:0]  ob;
  logic        obe;
  int          lat, en_cyc;

  // Random-phase state
  logic        c_busy, h_busy;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_wstrb;
  logic        h_we;
  logic [AW-1:0] h_addr;
  logic [31:0] h_wdata;
  int          c_age, h_age, h_cpu_done, hi_cycles, host_acks, n_grants;
  logic [31:0] exp_val, exp_wait;
  logic        mmio, oor, stalled;
  int          seq [18];

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.cpu_valid = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_wstrb = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {bus.cpu_ready, bus.host_ack, bus.sram_en, bus.sram_we,
                      bus.out_byte_en, bus.out_byte}, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_host_rdata", bus.host_rdata, 0);
    check("rst_sram_addr", bus.sram_addr, 0);
    check("rst_sram_wdata", bus.sram_wdata, 0);
    check("rst_wait_cnt", bus.host_wait_cycles, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Preload the working window through the host port.
    for (int w = 0; w < NWORDS; w++) begin
      gold[w] = (w == 5) ? 32'hDEAD_BEEF : (w == 3) ? 32'h0 : $urandom;
      host_op(1'b1, AW'(w), gold[w], rd, lat);
      check("preload_lat", lat, 2);
      check("preload_rdata", rd, 0);
    end

    cpu_op(32'd20, 32'h0, 4'h0, rd, lat, en_cyc, obe, ob);
    check("rd5_data", rd, 32'hDEAD_BEEF);
    check("rd5_lat", lat, 2);
    check("rd5_en_cycles", en_cyc, 1);
    check("rd5_obe", obe, 0);
    check("rdata_hold", bus.cpu_rdata, 32'hDEAD_BEEF);

    cpu_op(OB_ADDR, 32'h0000_0041, 4'hF, rd, lat, en_cyc, obe, ob);
    check("mmio_lat", lat, 1);
    check("mmio_obe", obe, 1);
    check("mmio_byte", ob, 8'h41);
    check("mmio_no_sram", en_cyc, 0);
    check("mmio_byte_hold", bus.out_byte, 8'h41);

    cpu_op(32'd12, 32'h0000_AB00, 4'b0010, rd, lat, en_cyc, obe, ob);
    gold[3] = merge(gold[3], 32'h0000_AB00, 4'b0010);
    check("wstrb_wr_lat", lat, 2);
    check("wstrb_wr_rdata", rd, 0);
    host_op(1'b0, AW'(3), 32'h0, rd, lat);
    check("wstrb_host_rd", rd, 32'h0000_AB00);
    check("wstrb_host_lat", lat, 2);

    cpu_op(32'h0001_0000, 32'h0, 4'h0, rd, lat, en_cyc, obe, ob);
    check("oor_rd_lat", lat, 1);
    check("oor_rd_data", rd, 0);
    check("oor_rd_no_sram", en_cyc, 0);
    cpu_op(32'h0001_0000, 32'hCAFE_F00D, 4'hF, rd, lat, en_cyc, obe, ob);
    check("oor_wr_lat", lat, 1);
    check("oor_wr_no_sram", en_cyc, 0);
    host_op(1'b0, AW'(0), 32'h0, rd, lat);
    check("oor_wr_dropped", rd, gold[0]);

    // Both requesters continuously asserted: expect STARVE_LIMIT CPU grants per host grant.
    bus.cpu_valid = 1'b1; bus.cpu_addr = 32'd0; bus.cpu_wstrb = 4'h0;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = AW'(1);
    n_grants = 0;
    for (int cyc = 0; cyc < 400 && n_grants < 18; cyc++) begin
      @(posedge clk); #1;
      if (bus.cpu_ready) begin
        check("b2b_cpu_rdata", bus.cpu_rdata, gold[0]);
        seq[n_grants] = 0;
        n_grants++;
      end
      if (bus.host_ack) begin
        check("b2b_host_rdata", bus.host_rdata, gold[1]);
        seq[n_grants] = 1;
        n_grants++;
      end
    end
    bus.cpu_valid = 1'b0;
    bus.host_req = 1'b0;
    check("b2b_grants", n_grants, 18);
    for (int i = 0; i < n_grants; i++) begin
      check("b2b_seq", seq[i], ((i + 1) % (STARVE_LIMIT + 1) == 0) ? 1 : 0);
    end
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an SRAM access.
    bus.cpu_valid = 1'b1; bus.cpu_addr = 32'd28; bus.cpu_wstrb = 4'h0;
    @(posedge clk); #1;
    check("rst_mid_access", bus.sram_en, 1);
    #2 resetn = 1'b0;
    #1;
    check("rst_async_ctl", {bus.cpu_ready, bus.host_ack, bus.sram_en, bus.sram_we,
                            bus.out_byte_en, bus.out_byte}, 0);
    check("rst_async_addr", bus.sram_addr, 0);
    check("rst_async_rdata", bus.cpu_rdata, 0);
    check("rst_async_wait", bus.host_wait_cycles, 0);
    bus.cpu_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_no_pulse", {bus.cpu_ready, bus.host_ack, bus.sram_en}, 0);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    cpu_op(32'd28, 32'h0, 4'h0, rd, lat, en_cyc, obe, ob);
    check("post_rst_lat", lat, 2);
    check("post_rst_data", rd, gold[7]);

    // Randomized mixed traffic against the transaction-level reference.
    c_busy = 1'b0; h_busy = 1'b0; c_age = 0; h_age = 0; h_cpu_done = 0;
    hi_cycles = 0; host_acks = 0; stalled = 1'b0;
    for (int cyc = 0; cyc < 4200 && !stalled; cyc++) begin
      if (bus.host_req) hi_cycles++;
      @(posedge clk); #1;
      check("excl", {bus.cpu_ready & bus.host_ack, bus.out_byte_en & ~bus.cpu_ready}, 0);
      if (bus.cpu_ready) begin
        mmio = (c_addr == OB_ADDR) && (c_wstrb != 4'h0);
        oor  = (c_addr >> 2) >= MEM_SIZE;
        check("rnd_obe", bus.out_byte_en, mmio);
        if (mmio) begin
          check("rnd_out_byte", bus.out_byte, c_wdata[7:0]);
          exp_val = 32'h0;
        end else if (c_wstrb == 4'h0) begin
          exp_val = oor ? 32'h0 : gold[c_addr >> 2];
        end else begin
          exp_val = 32'h0;
          if (!oor) gold[c_addr >> 2] = merge(gold[c_addr >> 2], c_wdata, c_wstrb);
        end
        check("rnd_cpu_rdata", bus.cpu_rdata, exp_val);
        c_busy = 1'b0;
        if (h_busy) h_cpu_done++;
      end
      if (bus.host_ack) begin
        exp_val = h_we ? 32'h0 : gold[h_addr];
        if (h_we) gold[h_addr] = h_wdata;
        check("rnd_host_rdata", bus.host_rdata, exp_val);
        check("host_starve_bound", h_cpu_done <= STARVE_LIMIT + 1, 1);
        h_busy = 1'b0;
        host_acks++;
      end
      if (c_busy) c_age++;
      if (h_busy) h_age++;
      if (c_age > 60 || h_age > 80) begin
        check("rnd_timeout", {c_age > 60, h_age > 80}, 0);
        stalled = 1'b1;
      end
      if (!c_busy) begin
        c_age = 0;
        bus.cpu_valid = 1'b0;
        if (cyc < 4000 && $urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 9))
            0: begin c_addr = OB_ADDR; c_wstrb = 4'($urandom_range(0, 15)); end
            1: begin
              c_addr = (MEM_SIZE + $urandom_range(0, 50000)) << 2;
              c_wstrb = 4'($urandom_range(0, 15));
            end
            default: begin
              c_addr = $urandom_range(0, NWORDS - 1) << 2;
              c_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
          endcase
          c_wdata = $urandom;
          bus.cpu_valid = 1'b1; bus.cpu_addr = c_addr;
          bus.cpu_wdata = c_wdata; bus.cpu_wstrb = c_wstrb;
          c_busy = 1'b1;
        end
      end
      if (!h_busy) begin
        h_age = 0;
        h_cpu_done = 0;
        bus.host_req = 1'b0;
        if (cyc < 4000 && $urandom_range(0, 2) == 0) begin
          h_we = 1'($urandom_range(0, 1));
          h_addr = AW'($urandom_range(0, NWORDS - 1));
          h_wdata = $urandom;
          bus.host_req = 1'b1; bus.host_we = h_we;
          bus.host_addr = h_addr; bus.host_wdata = h_wdata;
          h_busy = 1'b1;
        end
      end
    end
    check("rnd_drained", {c_busy, h_busy}, 0);

`ifdef ARB_PERF_CNT_EN
    exp_wait = 32'(hi_cycles - host_acks);
`else
    exp_wait = 32'h0;
`endif
    check("host_wait_cycles", bus.host_wait_cycles, exp_wait);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/picorv_mem_arbiter.md
Name: picorv_mem_arbiter

Overview:
- Shares the single-port on-chip firmware SRAM between two requesters.
- Requester 1 is the PicoRV32 native memory interface (valid/ready).
- Requester 2 is a host access port, driven by the CW305 USB register bank, which loads and inspects firmware/data while the core runs.
- Also decodes the out_byte MMIO write.
- Sits between picorv32, the SRAM macro and the CW305 register block in the system top.

Parameters:
- MEM_SIZE, 4096: SRAM depth in 32-bit words.
- AW, 12: SRAM word-address width; must satisfy 2**AW >= MEM_SIZE.
- STARVE_LIMIT, 8: consecutive CPU grants while host waits before host is forced through; range 1..255.
- OUT_BYTE_ADDR, 32'h1000_0000: CPU byte address of out_byte MMIO.

Ports:
- clk  in  1  single clock for all logic
- resetn  in  1  asynchronous, active-low reset
- cpu_valid  in  1  picorv32 mem_valid
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_wstrb  in  4  byte strobes; 0 = read
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid while cpu_ready
- host_req  in  1  level; held until host_ack
- host_we  in  1  1 = full-word write
- host_addr  in  AW  word address
- host_wdata  in  32  write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  32  read data, valid while host_ack
- sram_en  out  1  SRAM access enable
- sram_we  out  4  byte write enables
- sram_addr  out  AW  word address
- sram_wdata  out  32  write data
- sram_rdata  in  32  synchronous read data, valid one cycle after sram_en
- out_byte  out  8  last byte written to OUT_BYTE_ADDR
- out_byte_en  out  1  one-cycle strobe with out_byte
- host_wait_cycles  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; starvation count 0. Reset is asynchronous and may assert mid-access; the in-flight access is abandoned with no ready/ack pulse.
- FSM states: IDLE, ACCESS, RESP. All sram_* outputs are registered.
- IDLE grant rules:
  - Only CPU pending: CPU granted.
  - Only host pending: host granted.
  - Both pending: CPU granted unless starve_cnt == STARVE_LIMIT, in which case host is granted.
- starve_cnt:
  - Increments on each CPU grant while host_req is high.
  - Clears on host grant, or when host_req is low.
  - Saturates at STARVE_LIMIT.
- CPU MMIO write (cpu_addr == OUT_BYTE_ADDR, wstrb != 0): no SRAM access. Next cycle: out_byte <= cpu_wdata[7:0], out_byte_en = 1, cpu_ready = 1. FSM: IDLE -> RESP.
- CPU out-of-range (cpu_addr >> 2 >= MEM_SIZE, not MMIO): no SRAM access.
  - Reads return 0.
  - Writes are dropped.
  - cpu_ready is asserted next cycle, via RESP.
- In-range grant: registers sram_en = 1 and sram_addr.
  - sram_we = cpu_wstrb for CPU, 4'hF for a host write, 0 for reads.
  - FSM: IDLE -> ACCESS.
- ACCESS: sram_en deasserts; FSM -> RESP.
- RESP:
  - Pulse cpu_ready or host_ack for exactly one cycle.
  - rdata is captured from sram_rdata; it is 0 for writes.
  - FSM -> IDLE.
- Latency: grant cycle + 2 cycles to ready/ack for SRAM accesses; + 1 cycle for MMIO or out-of-range.
- Requesters must drop or renew their request the cycle after ready/ack. A request seen in IDLE after RESP is treated as a new access.
- Requests arriving during ACCESS or RESP wait in IDLE. There is no queueing beyond one outstanding access.
- cpu_rdata and host_rdata hold their value until the next respective pulse.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: host_wait_cycles counts cycles with host_req high and no host grant. It wraps at 2**32 and clears only on reset.
- Undefined: host_wait_cycles is constant 0 and the counter logic is not built.

Decomposition:
- Package picorv_mem_pkg holds:
  - state enum {IDLE, ACCESS, RESP}
  - grant enum {GNT_NONE, GNT_CPU, GNT_HOST}
  - default constants MEM_SIZE and OUT_BYTE_ADDR
- One sub-module, picorv_mem_grant: priority plus starvation counter. It takes cpu_pend, host_pend and an arb_en strobe, and outputs the grant enum.

Test Plan:
- CPU read of word 5 (holding 32'hDEADBEEF), host idle -> sram_en high 1 cycle, cpu_ready 2 cycles after grant, cpu_rdata = 32'hDEADBEEF.
- CPU write 0x1000_0000, wdata 32'h0000_0041 -> out_byte = 8'h41, out_byte_en and cpu_ready pulse together, 1 cycle after grant; sram_en never asserted.
- CPU and host requesting back-to-back continuously, STARVE_LIMIT = 8 -> pattern is 8 CPU grants then 1 host grant; host_ack occurs within 9 grants.
- CPU write wstrb 4'b0010, wdata 32'h0000_AB00 to word 3 (holding 0) -> host read of word 3 returns 32'h0000_AB00.
- CPU read at byte address 0x0001_0000 (word 16384, MEM_SIZE 4096) -> cpu_ready 1 cycle after grant with rdata 0; CPU write to the same address is dropped.
- resetn pulsed low during ACCESS -> all outputs 0 immediately, no ready/ack pulse, FSM in IDLE; with ARB_PERF_CNT_EN, host_wait_cycles = 0.
